trgg_sched: RTL and testbench

Command scheduler in front of the `trgg` trigger-generator block. It buffers trigger commands from the host-side command decoder in a small FIFO and issues each one to `trgg` over the fs/fd handshake. Each command can be repeated a set number of times with a programmable idle gap between repeats. The block also applies a handshake timeout and supports abort, and reports busy, done and error status to the status/readback path.

---
 rtl/trgg_pkg.sv | 24 ++
 rtl/trgg_fifo.sv | 49 ++++
 rtl/trgg_sched.sv | 179 +++++++++++++++++
 tb/tb_trgg_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trgg_pkg.sv
// Shared types and constants for the trgg command scheduler.
package trgg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_RELEASE = 3'd2,
      ST_GAP     = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   // Command word layout, MSB-first: trgg_cmd | rpt | gap
   localparam int TRGG_W   = 40;
   localparam int RPT_W    = 8;
   localparam int GAP_W    = 8;
   localparam int CMD_W    = TRGG_W + RPT_W + GAP_W;
   localparam int TRGG_OFS = 0;
   localparam int RPT_OFS  = TRGG_W;
   localparam int GAP_OFS  = TRGG_W + RPT_W;

   localparam int WAIT_W      = 16;
   localparam int TIMEOUT_DEF = 65535;

endpackage

// File: rtl/trgg_fifo.sv
// First-word-fall-through command FIFO; push and pop may coincide, even when full.
module trgg_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 56
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/trgg_sched.sv
// Queues trigger commands and issues each one (rpt+1 times, gap idle cycles apart)
// to trgg over the fs/fd handshake, with handshake timeout and abort.
//
// state   | meaning
// IDLE    | waiting for a queued command
// START   | fs high, waiting for fd to rise
// RELEASE | fs low, waiting for fd to fall
// GAP     | idle cycles between repeats
// HALT    | after abort, waiting for fd to fall
module trgg_sched
   import trgg_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [0:CMD_W-1]  cmd_data,
   output logic              cmd_ready,
   input  logic              abort,
   input  logic              err_clr,
   output logic              trgg_fs,
   input  logic              trgg_fd,
   output logic [0:TRGG_W-1] trgg_cmd,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t               state, state_nxt;
   logic [0:CMD_W-1]     fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                 pop;
   logic                 load;
   logic                 rep_dec;
   logic                 gap_load;
   logic                 gap_dec;
   logic                 wait_clr;
   logic                 wait_hit;
   logic                 err_set;
   logic                 done_nxt;
   logic [RPT_W-1:0]     rep_cnt;
   logic [GAP_W-1:0]     gap_reg;
   logic [GAP_W-1:0]     gap_cnt;
   logic [WAIT_W-1:0]    wait_cnt;

   trgg_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready && !abort),
      .pop   (pop),
      .flush (abort),
      .din   (cmd_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign cmd_ready = !fifo_full;
   assign busy      = (state != ST_IDLE) || (fifo_count != '0);
   // High during the TIMEOUT-th cycle spent waiting for an fd edge
   assign wait_hit  = (wait_cnt == WAIT_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load      = 1'b0;
      rep_dec   = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
      wait_clr  = 1'b0;
      err_set   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!abort && !fifo_empty) begin
               pop       = 1'b1;
               load      = 1'b1;
               wait_clr  = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (abort) begin
               wait_clr  = 1'b1;
               state_nxt = ST_HALT;
            end else if (trgg_fd) begin
               wait_clr  = 1'b1;
               state_nxt = ST_RELEASE;
            end else if (wait_hit) begin
               err_set   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_RELEASE: begin
            if (abort) begin
               wait_clr  = 1'b1;
               state_nxt = ST_HALT;
            end else if (!trgg_fd) begin
               if (rep_cnt == '0) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  rep_dec = 1'b1;
                  if (gap_reg == '0) begin
                     wait_clr  = 1'b1;
                     state_nxt = ST_START;
                  end else begin
                     gap_load  = 1'b1;
                     state_nxt = ST_GAP;
                  end
               end
            end else if (wait_hit) begin
               err_set   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else begin
               gap_dec = 1'b1;
               if (gap_cnt == GAP_W'(1)) begin
                  wait_clr  = 1'b1;
                  state_nxt = ST_START;
               end
            end
         end
         ST_HALT: begin
            if (!trgg_fd) begin
               state_nxt = ST_IDLE;
            end else if (wait_hit) begin
               err_set   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         trgg_fs  <= 1'b0;
         trgg_cmd <= '0;
         rep_cnt  <= '0;
         gap_reg  <= '0;
         gap_cnt  <= '0;
         wait_cnt <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state   <= state_nxt;
         trgg_fs <= (state_nxt == ST_START);
         done    <= done_nxt;
         if (load) begin
            trgg_cmd <= fifo_dout[TRGG_OFS +: TRGG_W];
            rep_cnt  <= fifo_dout[RPT_OFS +: RPT_W];
            gap_reg  <= fifo_dout[GAP_OFS +: GAP_W];
         end else if (rep_dec) begin
            rep_cnt <= rep_cnt - RPT_W'(1);
         end
         if (gap_load)     gap_cnt <= gap_reg;
         else if (gap_dec) gap_cnt <= gap_cnt - GAP_W'(1);
         if (wait_clr)
            wait_cnt <= '0;
         else if (state == ST_START || state == ST_RELEASE || state == ST_HALT)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         // set has priority over clear
         if (err_set)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trgg_sched.sv
// Directed bench for trgg_sched with a behavioural trgg responder and an fs/fd monitor.
module tb_trgg_sched;

   localparam int DEPTH = 4;
   localparam int TMO   = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid;
   logic [0:55] cmd_data;
   logic        cmd_ready;
   logic        abort;
   logic        err_clr;
   logic        trgg_fs;
   logic        trgg_fd = 1'b0;
   logic [0:39] trgg_cmd;
   logic        busy;
   logic        done;
   logic        err;

   trgg_sched #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_data  (cmd_data),
      .cmd_ready (cmd_ready),
      .abort     (abort),
      .err_clr   (err_clr),
      .trgg_fs   (trgg_fs),
      .trgg_fd   (trgg_fd),
      .trgg_cmd  (trgg_cmd),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // trgg model (mode 0: fd 3 cycles after fs, 1: stalled, 2: fd forced) and monitor
   int          fd_mode  = 0;
   logic        fd_force = 1'b0;
   int          lat_cnt  = 0;
   logic        prev_fs  = 1'b0;
   logic [39:0] held_cmd = '0;
   int          hi_run   = 0;
   int          lo_cnt   = 0;
   int          fs_rises = 0;
   int          done_cnt = 0;
   int          cmd_unstable = 0;
   logic [39:0] cmd_log[$];
   int          gap_log[$];
   int          hi_log[$];

   always @(negedge clk) begin
      if (trgg_fs && !prev_fs) begin
         fs_rises++;
         cmd_log.push_back(trgg_cmd);
         gap_log.push_back(lo_cnt);
         lo_cnt = 0;
         hi_run = 0;
      end
      if (trgg_fs && prev_fs && trgg_cmd != held_cmd) cmd_unstable++;
      if (trgg_fs) begin
         held_cmd = trgg_cmd;
         hi_run++;
      end
      if (!trgg_fs && prev_fs) hi_log.push_back(hi_run);
      if (!trgg_fs && !trgg_fd) lo_cnt++;
      if (done) done_cnt++;
      prev_fs = trgg_fs;
      case (fd_mode)
         0: begin
            if (trgg_fs && !trgg_fd) begin
               lat_cnt++;
               if (lat_cnt == 3) trgg_fd = 1'b1;
            end else if (!trgg_fs) begin
               trgg_fd = 1'b0;
               lat_cnt = 0;
            end
         end
         1: begin
            trgg_fd = 1'b0;
            lat_cnt = 0;
         end
         default: trgg_fd = fd_force;
      endcase
   end

   function automatic logic [63:0] log_cmd(input int i);
      return (i < cmd_log.size()) ? 64'(cmd_log[i]) : '1;
   endfunction
   function automatic int log_gap(input int i);
      return (i < gap_log.size()) ? gap_log[i] : -1;
   endfunction
   function automatic int log_hi(input int i);
      return (i < hi_log.size()) ? hi_log[i] : -1;
   endfunction

   function automatic logic [55:0] mk(input logic [7:0] m, input logic [31:0] d,
                                      input logic [7:0] r, input logic [7:0] g);
      return {m, d, r, g};
   endfunction

   task automatic clear_mon();
      @(posedge clk);
      fs_rises = 0; done_cnt = 0; cmd_unstable = 0; lo_cnt = 0;
      cmd_log.delete(); gap_log.delete(); hi_log.delete();
   endtask

   task automatic set_mode(input int m, input logic f);
      @(posedge clk); #1;
      fd_mode  = m;
      fd_force = f;
   endtask

   task automatic push(input logic [55:0] d, output logic rdy);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      rdy       = cmd_ready;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < max);
      chk({tag, "_idle"}, 64'(busy), 64'(0));
      @(posedge clk);
   endtask

   task automatic wait_fs(input string tag, input logic v, input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (trgg_fs !== v && n < max);
      chk({tag, "_fs_wait"}, 64'(trgg_fs), 64'(v));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_fs"},    64'(trgg_fs),   64'(0));
      chk({tag, "_cmd"},   64'(trgg_cmd),  64'(0));
      chk({tag, "_ready"}, 64'(cmd_ready), 64'(1));
      chk({tag, "_busy"},  64'(busy),      64'(0));
      chk({tag, "_done"},  64'(done),      64'(0));
      chk({tag, "_err"},   64'(err),       64'(0));
   endtask

   initial begin
      logic        rdy;
      logic [55:0] cw [6];
      int          n;

      cmd_valid = 1'b0;
      cmd_data  = '0;
      abort     = 1'b0;
      err_clr   = 1'b0;

      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b1;

      // single command
      clear_mon();
      push(mk(8'h12, 32'h0000_0040, 8'd0, 8'd0), rdy);
      chk("single_fs_n1", 64'(trgg_fs), 64'(0));
      chk("single_busy", 64'(busy), 64'(1));
      @(negedge clk);
      chk("single_fs_n2", 64'(trgg_fs), 64'(1));
      chk("single_cmd", 64'(trgg_cmd), 64'h12_0000_0040);
      wait_idle("single", 100);
      chk("single_rises", 64'(fs_rises), 64'(1));
      chk("single_hi", 64'(log_hi(0)), 64'(3));
      chk("single_done", 64'(done_cnt), 64'(1));
      chk("single_stable", 64'(cmd_unstable), 64'(0));

      // repeat with gap
      clear_mon();
      push(mk(8'h34, 32'h0000_0001, 8'd2, 8'd5), rdy);
      wait_idle("rpt", 200);
      chk("rpt_rises", 64'(fs_rises), 64'(3));
      chk("rpt_gap1", 64'(log_gap(1)), 64'(5));
      chk("rpt_gap2", 64'(log_gap(2)), 64'(5));
      chk("rpt_cmd2", log_cmd(2), 64'h34_0000_0001);
      chk("rpt_done", 64'(done_cnt), 64'(1));

      // FIFO full while trgg stalled behind a blocker command
      set_mode(1, 1'b0);
      clear_mon();
      for (int i = 0; i < 6; i++) cw[i] = mk(8'(8'h20 + i), 32'(i * 32'h111), 8'd0, 8'd0);
      push(cw[0], rdy);
      repeat (2) @(negedge clk);
      for (int i = 1; i < 6; i++) begin
         push(cw[i], rdy);
         if (i == 3) chk("full_ready3", 64'(rdy), 64'(1));
         if (i == 4) chk("full_ready4", 64'(rdy), 64'(0));
      end
      set_mode(0, 1'b0);
      wait_idle("full", 500);
      chk("full_rises", 64'(fs_rises), 64'(5));
      chk("full_done", 64'(done_cnt), 64'(5));
      for (int i = 0; i < 5; i++) chk($sformatf("full_cmd%0d", i), log_cmd(i), 64'(cw[i][55:16]));
      chk("full_b2b_gap", 64'(log_gap(2)), 64'(1));

      // handshake timeout, then the next queued command proceeds
      set_mode(1, 1'b0);
      clear_mon();
      push(mk(8'h55, 32'h0000_0AAA, 8'd3, 8'd0), rdy);
      push(mk(8'h66, 32'h0000_0BBB, 8'd0, 8'd0), rdy);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!err && n < 300);
      chk("tmo_err", 64'(err), 64'(1));
      chk("tmo_fs_low", 64'(trgg_fs), 64'(0));
      set_mode(0, 1'b0);
      wait_idle("tmo", 200);
      chk("tmo_hi", 64'(log_hi(0)), 64'(TMO));
      chk("tmo_rises", 64'(fs_rises), 64'(2));
      chk("tmo_next_cmd", log_cmd(1), 64'h66_0000_0BBB);
      chk("tmo_done", 64'(done_cnt), 64'(1));
      chk("tmo_sticky", 64'(err), 64'(1));
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_clr", 64'(err), 64'(0));

      // abort mid-START with fd rising in the same cycle, two commands queued
      set_mode(1, 1'b0);
      clear_mon();
      push(mk(8'h71, 32'h1, 8'd0, 8'd0), rdy);
      push(mk(8'h72, 32'h2, 8'd0, 8'd0), rdy);
      push(mk(8'h73, 32'h3, 8'd0, 8'd0), rdy);
      set_mode(2, 1'b1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_fs", 64'(trgg_fs), 64'(0));
      chk("abort_ready", 64'(cmd_ready), 64'(1));
      repeat (4) @(negedge clk);
      chk("abort_halt_busy", 64'(busy), 64'(1));
      set_mode(2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_idle", 64'(busy), 64'(0));
      repeat (20) @(negedge clk);
      @(posedge clk);
      chk("abort_rises", 64'(fs_rises), 64'(1));
      chk("abort_nodone", 64'(done_cnt), 64'(0));
      set_mode(0, 1'b0);

      // one-cycle reset while in GAP
      clear_mon();
      push(mk(8'h9A, 32'hDEAD_BEEF, 8'd3, 8'd10), rdy);
      wait_fs("rg_hi", 1'b1, 20);
      wait_fs("rg_lo", 1'b0, 20);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_reset_vals("rg");
      repeat (30) @(negedge clk);
      @(posedge clk);
      chk("rg_rises", 64'(fs_rises), 64'(1));
      chk("rg_nodone", 64'(done_cnt), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
